// File: rtl/led_cmd_pkg.sv
// Shared definitions for the UART LED command front-end.
//   state_e   : frame parser / responder states
//   CMD_*     : command codes carried in the CMD byte
//   RSP_*     : response bytes returned to the UART transmitter
//   cmd_valid : true when a CMD/ARG pair names an executable command
package led_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_ARG,
    GET_CHK,
    EXEC,
    RESP
  } state_e;

  localparam logic [7:0] CMD_SET_MODE = 8'h01;
  localparam logic [7:0] CMD_BREATH   = 8'h02;
  localparam logic [7:0] CMD_FLOW     = 8'h03;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  localparam logic [7:0] DEFAULT_HDR = 8'hA5;

  function automatic logic cmd_valid(input logic [7:0] cmd, input logic [7:0] arg);
    logic ok;
    ok = 1'b0;
    case (cmd)
      CMD_SET_MODE: ok = (arg[7:2] == 6'd0);
      CMD_BREATH:   ok = 1'b1;
      CMD_FLOW:     ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/led_cmd_timeout.sv
// Inter-byte gap counter.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : count while high, held at zero while low
//   clr        : restart the gap (byte received); overrides expiry
//   expire     : high in the cycle the count reaches the limit
module led_cmd_timeout #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned TIMEOUT_MS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned TO_CYC = CLK_FREQ / 1000 * TIMEOUT_MS - 1;
  localparam int unsigned CW     = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TO_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_lim;

  always_comb begin
    at_lim = (cnt_q == TO_LIM);
    expire = en && !clr && at_lim;
    if (!en || clr || at_lim) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_uart_cmd.sv
// UART command front-end for the LED path.
// Parses HDR,CMD,ARG,CHK frames (CHK = CMD ^ ARG) into LED controls and
// answers each complete frame with ACK/NAK over a req/ready handshake.
//   sys_clk, rst_n : clock, synchronous active-low reset
//   rx_data/rx_flag: received byte and its 1-cycle valid strobe
//   tx_ready       : transmitter accepts a byte
//   tx_data/tx_req : response byte, request held until tx_ready
//   led_switch     : LED source select (registered, holds between frames)
//   b_en/f_en      : 1-cycle pattern latch strobes
//   frame_err      : 1-cycle strobe on NAK or inter-byte timeout
module led_uart_cmd
  import led_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned TIMEOUT_MS = 10,
  parameter logic [7:0]  HDR_BYTE   = DEFAULT_HDR
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_flag,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_req,
  output logic [1:0] led_switch,
  output logic       b_en,
  output logic       f_en,
  output logic       frame_err
);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] arg_q, arg_d;
  logic       chk_ok_q, chk_ok_d;
  logic [1:0] led_switch_q, led_switch_d;
  logic       b_en_q, b_en_d;
  logic       f_en_q, f_en_d;
  logic       frame_err_q, frame_err_d;
  logic       tx_req_q, tx_req_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       chk_now;
  logic       to_en;
  logic       to_expire;

  assign to_en = (state_q == GET_CMD) || (state_q == GET_ARG) || (state_q == GET_CHK);

  led_cmd_timeout #(
    .CLK_FREQ  (CLK_FREQ),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) u_timeout (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .en    (to_en),
    .clr   (rx_flag),
    .expire(to_expire)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    chk_ok_d     = chk_ok_q;
    led_switch_d = led_switch_q;
    b_en_d       = 1'b0;
    f_en_d       = 1'b0;
    frame_err_d  = 1'b0;
    tx_req_d     = tx_req_q;
    tx_data_d    = tx_data_q;
    chk_now      = (rx_data == (cmd_q ^ arg_q));

    unique case (state_q)
      IDLE: begin
        if (rx_flag && (rx_data == HDR_BYTE)) state_d = GET_CMD;
      end
      GET_CMD: begin
        if (rx_flag) begin
          cmd_d   = rx_data;
          state_d = GET_ARG;
        end else if (to_expire) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      GET_ARG: begin
        if (rx_flag) begin
          arg_d   = rx_data;
          state_d = GET_CHK;
        end else if (to_expire) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      GET_CHK: begin
        if (rx_flag) begin
          chk_ok_d = chk_now;
          state_d  = EXEC;
          // Effects are registered on the CHK strobe so that the strobes
          // and the new led_switch are visible during the EXEC cycle.
          if (chk_now && cmd_valid(cmd_q, arg_q)) begin
            case (cmd_q)
              CMD_SET_MODE: led_switch_d = arg_q[1:0];
              CMD_BREATH:   b_en_d       = 1'b1;
              CMD_FLOW:     f_en_d       = 1'b1;
              default:      ;
            endcase
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (to_expire) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      EXEC: begin
        tx_req_d  = 1'b1;
        tx_data_d = (chk_ok_q && cmd_valid(cmd_q, arg_q)) ? RSP_ACK : RSP_NAK;
        state_d   = RESP;
      end
      RESP: begin
        if (tx_ready) begin
          tx_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      arg_q        <= '0;
      chk_ok_q     <= 1'b0;
      led_switch_q <= 2'b00;
      b_en_q       <= 1'b0;
      f_en_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      tx_req_q     <= 1'b0;
      tx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      chk_ok_q     <= chk_ok_d;
      led_switch_q <= led_switch_d;
      b_en_q       <= b_en_d;
      f_en_q       <= f_en_d;
      frame_err_q  <= frame_err_d;
      tx_req_q     <= tx_req_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_req     = tx_req_q;
  assign led_switch = led_switch_q;
  assign b_en       = b_en_q;
  assign f_en       = f_en_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_led_uart_cmd.sv
// Directed bench for led_uart_cmd with a response scoreboard.
module tb_led_uart_cmd;

  localparam int unsigned CLK_FREQ   = 10_000;
  localparam int unsigned TIMEOUT_MS = 2;
  localparam int unsigned TO_CYC     = CLK_FREQ / 1000 * TIMEOUT_MS - 1;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [1:0] led_switch;
  logic       b_en;
  logic       f_en;
  logic       frame_err;

  int vectors = 0;
  int errors  = 0;
  int hs_cnt  = 0;
  int b_cnt   = 0;
  int f_cnt   = 0;
  int err_cnt = 0;

  logic [7:0] exp_q[$];
  logic [1:0] led_exp = 2'b00;

  always #5 sys_clk = ~sys_clk;

  led_uart_cmd #(
    .CLK_FREQ  (CLK_FREQ),
    .TIMEOUT_MS(TIMEOUT_MS),
    .HDR_BYTE  (8'hA5)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_flag   (rx_flag),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .led_switch(led_switch),
    .b_en      (b_en),
    .f_en      (f_en),
    .frame_err (frame_err)
  );

  // Scoreboard side: every accepted response byte is popped and compared.
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (b_en) b_cnt++;
      if (f_en) f_cnt++;
      if (frame_err) err_cnt++;
      if (b_en && f_en) begin
        vectors++;
        assert (1'b0) else begin
          errors++;
          $error("FAIL b_f_exclusive obs=%b%b exp=not both", b_en, f_en);
        end
      end
      if (tx_req && tx_ready) begin
        hs_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          assert (1'b0) else begin
            errors++;
            $error("FAIL unexpected_resp obs=%h exp=none", tx_data);
          end
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          assert (tx_data === e) else begin
            errors++;
            $error("FAIL resp_byte obs=%h exp=%h", tx_data, e);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_flag = 1'b1;
    tick();
    rx_flag = 1'b0;
  endtask

  // Sends a full frame, predicts the response, and checks the EXEC cycle
  // and the first RESP cycle.
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk);
    logic ok;
    logic [7:0] rsp;
    ok = (chk == (cmd ^ arg)) &&
         ((cmd == 8'h01 && arg[7:2] == 6'd0) || cmd == 8'h02 || cmd == 8'h03);
    rsp = ok ? 8'h06 : 8'h15;
    if (ok && cmd == 8'h01) led_exp = arg[1:0];
    exp_q.push_back(rsp);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(arg);
    send_byte(chk);
    check("exec_led", led_switch, led_exp);
    check("exec_b_en", b_en, ok && cmd == 8'h02);
    check("exec_f_en", f_en, ok && cmd == 8'h03);
    check("exec_frame_err", frame_err, !ok);
    check("exec_no_req", tx_req, 1'b0);
    tick();
    check("resp_req", tx_req, 1'b1);
    check("resp_data", tx_data, rsp);
  endtask

  initial begin
    int hs0, b0, f0, e0;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_flag  = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_led", led_switch, 2'b00);
    check("rst_req", tx_req, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_strobes", {b_en, f_en, frame_err}, 3'b000);
    rst_n = 1'b1;
    tick();

    // Set mode to flow.
    hs0 = hs_cnt; e0 = err_cnt;
    run_frame(8'h01, 8'h02, 8'h03);
    tick();
    check("a_req_drop", tx_req, 1'b0);
    check("a_hs", hs_cnt - hs0, 1);
    check("a_err", err_cnt - e0, 0);

    // Breathing and flow strobes.
    b0 = b_cnt; f0 = f_cnt;
    run_frame(8'h02, 8'h00, 8'h02);
    tick();
    check("b_pulses", b_cnt - b0, 1);
    check("b_no_f", f_cnt - f0, 0);
    b0 = b_cnt; f0 = f_cnt;
    run_frame(8'h03, 8'h00, 8'h03);
    tick();
    check("f_pulses", f_cnt - f0, 1);
    check("f_no_b", b_cnt - b0, 0);

    // NAK cases: bad checksum, ARG out of range, unknown command.
    e0 = err_cnt;
    run_frame(8'h01, 8'h02, 8'hFF);
    tick();
    run_frame(8'h01, 8'h07, 8'h06);
    tick();
    run_frame(8'h09, 8'h00, 8'h09);
    tick();
    check("nak_err_pulses", err_cnt - e0, 3);
    check("nak_led_hold", led_switch, 2'b10);

    // Stray bytes before a frame.
    hs0 = hs_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    run_frame(8'h01, 8'h01, 8'h00);
    tick();
    check("stray_single_ack", hs_cnt - hs0, 1);

    // Timeout after A5 01.
    hs0 = hs_cnt; e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TO_CYC + 3) tick();
    check("to_err_pulse", err_cnt - e0, 1);
    check("to_no_resp", hs_cnt - hs0, 0);
    check("to_no_req", tx_req, 1'b0);
    run_frame(8'h01, 8'h00, 8'h01);
    tick();
    check("to_recover_ack", hs_cnt - hs0, 1);

    // Byte arriving exactly at expiry is accepted.
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TO_CYC) tick();
    send_byte(8'h03);
    led_exp = 2'b11;
    exp_q.push_back(8'h06);
    send_byte(8'h02);
    check("edge_led", led_switch, 2'b11);
    tick();
    check("edge_req", tx_req, 1'b1);
    tick();
    check("edge_no_err", err_cnt - e0, 0);

    // Stall in RESP with an injected header byte.
    tx_ready = 1'b0;
    hs0 = hs_cnt;
    run_frame(8'h02, 8'h00, 8'h02);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        send_byte(8'hA5);
      end else begin
        tick();
      end
      check("stall_req", tx_req, 1'b1);
      check("stall_data", tx_data, 8'h06);
    end
    tx_ready = 1'b1;
    tick();
    check("stall_hs", hs_cnt - hs0, 1);
    check("stall_req_drop", tx_req, 1'b0);
    // Without a header these bytes must not form a frame.
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h02);
    repeat (4) tick();
    check("stall_hdr_dropped", hs_cnt - hs0, 1);
    check("stall_led_hold", led_switch, 2'b11);

    // Reset during GET_ARG.
    send_byte(8'hA5);
    send_byte(8'h01);
    rst_n = 1'b0;
    tick();
    led_exp = 2'b00;
    check("mid_rst_led", led_switch, 2'b00);
    check("mid_rst_req", tx_req, 1'b0);
    check("mid_rst_data", tx_data, 8'h00);
    rst_n = 1'b1;
    tick();
    hs0 = hs_cnt;
    run_frame(8'h01, 8'h02, 8'h03);
    tick();
    check("post_rst_hs", hs_cnt - hs0, 1);

    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/led_uart_cmd.md
Name: led_uart_cmd

Overview:
- Command front-end for the UART-controlled LED path.
- Parses 4-byte frames from the UART receiver into LED control outputs: a registered mode select plus single-cycle breathing/flow enable strobes.
- Returns a 1-byte ACK or NAK to the UART transmitter over a request/ready handshake.
- Sits between the UART RX/TX blocks and the LED mode/output mux.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- TIMEOUT_MS, 10, maximum inter-byte gap inside a frame before the frame is aborted.
- HDR_BYTE, 8'hA5, frame header value.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- rx_data  in  8  received byte; valid only while rx_flag=1.
- rx_flag  in  1  1-cycle strobe: rx_data valid.
- tx_ready  in  1  transmitter can accept a byte.
- tx_data  out  8  response byte.
- tx_req  out  1  response valid; held until tx_ready.
- led_switch  out  2  LED source select (00 hold, 01 breathing, 10 flow, 11 hold).
- b_en  out  1  1-cycle strobe: latch breathing pattern.
- f_en  out  1  1-cycle strobe: latch flow pattern.
- frame_err  out  1  1-cycle strobe on NAK or timeout.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-low on rst_n; it is sampled on the sys_clk rising edge.
- Reset values: state=IDLE, led_switch=2'b00, b_en=0, f_en=0, tx_req=0, tx_data=8'h00, frame_err=0, timeout counter=0.
- Frame format: HDR, CMD, ARG, CHK, where CHK = CMD ^ ARG.
- FSM states: IDLE, GET_CMD, GET_ARG, GET_CHK, EXEC, RESP.
- IDLE: on rx_flag with rx_data==HDR_BYTE, go to GET_CMD. Any other byte is discarded silently and the FSM stays in IDLE.
- GET_CMD and GET_ARG: on rx_flag, latch the byte and advance.
- GET_CHK: on rx_flag, go to EXEC. Compare CHK here and register the result as chk_ok.
- EXEC: lasts exactly one cycle. Outputs depend on chk_ok and CMD:
  - chk_ok=0: NAK.
  - CMD=8'h01 with ARG[7:2]==0: led_switch<=ARG[1:0]; ACK.
  - CMD=8'h02: b_en=1 for this cycle only; ACK.
  - CMD=8'h03: f_en=1 for this cycle only; ACK.
  - CMD=8'h01 with ARG[7:2]!=0: NAK, led_switch unchanged.
  - Any other CMD: NAK, led_switch unchanged.
  - On NAK, frame_err=1 for this cycle.
  - Then go to RESP.
- Response bytes: ACK=8'h06, NAK=8'h15.
- RESP:
  - tx_req=1 and tx_data stable from the first RESP cycle.
  - The transfer completes on the cycle where tx_req & tx_ready; tx_req drops the next cycle and the FSM returns to IDLE.
  - tx_req never deasserts before tx_ready.
- Latency: last CHK byte strobe -> b_en/f_en/led_switch update is 1 cycle (EXEC). tx_req is asserted 2 cycles after that strobe.
- Timeout:
  - Counter limit TO_CYC = CLK_FREQ/1000*TIMEOUT_MS - 1; counter width is $clog2(TO_CYC+1).
  - The counter runs only in GET_CMD, GET_ARG and GET_CHK, and clears on every rx_flag and on state entry.
  - When the counter reaches TO_CYC: frame_err=1 for one cycle, return to IDLE, no response sent.
  - If rx_flag coincides with expiry, rx_flag wins: the byte is accepted and the counter clears.
- rx_flag during EXEC or RESP: the byte is dropped. It is not buffered and not counted as a header.
- A header byte seen mid-frame is treated as data (no resync).
- Reset asserted mid-frame or mid-RESP: everything returns to reset values next edge, and any pending tx_req is abandoned.
- led_switch holds its value between frames. b_en and f_en are never 1 simultaneously.

Decomposition:
- Package led_cmd_pkg holds:
  - the state enumeration;
  - CMD_SET_MODE=8'h01, CMD_BREATH=8'h02, CMD_FLOW=8'h03;
  - RSP_ACK=8'h06, RSP_NAK=8'h15;
  - default HDR_BYTE.
- One sub-module is natural: led_cmd_timeout, a parameterised gap counter with inputs en, clr and output expire. The FSM, decode and response logic stay in the top.

Test Plan:
- Frame A5 01 02 03, tx_ready=1 -> led_switch=2'b10 one cycle after CHK strobe; tx_data=06 with tx_req one cycle; frame_err=0.
- Frame A5 02 00 02 -> b_en high exactly 1 cycle, f_en=0, led_switch unchanged; ACK. Repeat with A5 03 00 03 -> f_en 1 cycle; ACK.
- Frame A5 01 02 FF (bad CHK) -> frame_err 1 cycle, tx_data=15, led_switch unchanged. Repeat with A5 01 07 06 (ARG out of range) -> same NAK behaviour.
- Stray bytes 00 FF 5A before A5 01 01 00 -> stray bytes ignored, led_switch=01, single ACK.
- A5 01 then no bytes for TO_CYC+1 cycles (TIMEOUT_MS reduced in bench) -> frame_err pulse, no tx_req, IDLE; next valid frame is accepted normally.
- Stall and reset cases:
  - Hold tx_ready=0 for 20 cycles in RESP -> tx_req and tx_data stable; an rx_flag injected during the stall is dropped.
  - rst_n=0 for 1 cycle during GET_ARG -> all outputs at reset values; a following complete frame is parsed correctly.
